chunked_rca_seq: RTL and testbench



---
 rtl/chunked_rca_seq_if.sv | 26 ++
 rtl/chunked_rca_seq.sv | 121 ++++++++++++
 tb/tb_chunked_rca_seq.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/chunked_rca_seq_if.sv
// rtl/chunked_rca_seq_if.sv - operand/result handshake bundle for chunked_rca_seq
interface chunked_rca_seq_if #(
    parameter int WIDTH = 16
) ();
    logic             En;
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    modport master (
        output En, start, mode, A, B, Cin,
        input  busy, done, Sum, Cout, Ovf
    );

    modport slave (
        input  En, start, mode, A, B, Cin,
        output busy, done, Sum, Cout, Ovf
    );
endinterface

// File: rtl/chunked_rca_seq.sv
// rtl/chunked_rca_seq.sv - multi-cycle chunked ripple-carry add/sub/accumulate unit
// Optional accumulate mode is enabled by defining RCA_ACCUM_EN.
module chunked_rca_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             Clk,
    input  logic             Rs,
    chunked_rca_seq_if.slave bus
);
    localparam int STEPS = WIDTH / CHUNK;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] opa_q, opb_q, part_q, sum_q;
    logic             cout_q, ovf_q, done_q, busy_q;

    logic             is_sub;
    logic [WIDTH-1:0] opa_d, opb_d, part_d;
    logic             carry_d;
    logic [CHUNK-1:0] chunk_a, chunk_b, chunk_s;
    logic             rc, c_top;
    logic             last_step;

`ifdef RCA_ACCUM_EN
    logic is_acc;
    assign is_sub = (bus.mode == 2'b01);
    assign is_acc = (bus.mode == 2'b10);
    assign opa_d  = is_acc ? sum_q : bus.A;
`else
    assign is_sub = bus.mode[0];
    assign opa_d  = bus.A;
`endif

    assign opb_d   = is_sub ? ~bus.B : bus.B;
    assign carry_d = is_sub ? 1'b1 : bus.Cin;

    // Operands shift right one chunk per step, so the active chunk is always the low one.
    assign chunk_a = opa_q[CHUNK-1:0];
    assign chunk_b = opb_q[CHUNK-1:0];

    always_comb begin
        rc      = carry_q;
        c_top   = carry_q;
        chunk_s = '0;
        for (int j = 0; j < CHUNK; j++) begin
            if (j == CHUNK - 1) c_top = rc;
            chunk_s[j] = chunk_a[j] ^ chunk_b[j] ^ rc;
            rc         = (chunk_a[j] & chunk_b[j]) | (rc & (chunk_a[j] ^ chunk_b[j]));
        end
    end

    // Result chunks enter at the top; after STEPS shifts chunk 0 sits at the LSB.
    if (CHUNK == WIDTH) begin : g_single
        assign part_d = chunk_s;
    end else begin : g_shift
        assign part_d = {chunk_s, part_q[WIDTH-1:CHUNK]};
    end

    assign last_step = (cnt_q == CNT_W'(STEPS - 1));

    always_ff @(posedge Clk or negedge Rs) begin
        if (!Rs) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        opa_q   <= opa_d;
                        opb_q   <= opb_d;
                        carry_q <= carry_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (bus.En) begin
                        opa_q   <= opa_q >> CHUNK;
                        opb_q   <= opb_q >> CHUNK;
                        part_q  <= part_d;
                        carry_q <= rc;
                        if (last_step) begin
                            sum_q   <= part_d;
                            cout_q  <= rc;
                            ovf_q   <= c_top ^ rc;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Sum  = sum_q;
    assign bus.Cout = cout_q;
    assign bus.Ovf  = ovf_q;
endmodule

// File: tb/tb_chunked_rca_seq.sv
// tb/tb_chunked_rca_seq.sv - directed-vector bench for chunked_rca_seq (CHUNK 4, 1 and 16)
module tb_chunked_rca_seq;
    logic        clk = 1'b0;
    logic        rs_n;
    logic        en_r;
    logic [1:0]  mode_r;
    logic [15:0] a_r, b_r;
    logic        cin_r;
    logic [2:0]  start_r;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    chunked_rca_seq_if #(.WIDTH(16)) if_c4  ();
    chunked_rca_seq_if #(.WIDTH(16)) if_c1  ();
    chunked_rca_seq_if #(.WIDTH(16)) if_c16 ();

    chunked_rca_seq #(.WIDTH(16), .CHUNK(4))  dut_c4  (.Clk(clk), .Rs(rs_n), .bus(if_c4));
    chunked_rca_seq #(.WIDTH(16), .CHUNK(1))  dut_c1  (.Clk(clk), .Rs(rs_n), .bus(if_c1));
    chunked_rca_seq #(.WIDTH(16), .CHUNK(16)) dut_c16 (.Clk(clk), .Rs(rs_n), .bus(if_c16));

    assign if_c4.En  = en_r;  assign if_c1.En  = en_r;  assign if_c16.En  = en_r;
    assign if_c4.mode = mode_r; assign if_c1.mode = mode_r; assign if_c16.mode = mode_r;
    assign if_c4.A   = a_r;   assign if_c1.A   = a_r;   assign if_c16.A   = a_r;
    assign if_c4.B   = b_r;   assign if_c1.B   = b_r;   assign if_c16.B   = b_r;
    assign if_c4.Cin = cin_r; assign if_c1.Cin = cin_r; assign if_c16.Cin = cin_r;
    assign if_c4.start  = start_r[0];
    assign if_c1.start  = start_r[1];
    assign if_c16.start = start_r[2];

    logic [2:0]  done_v, busy_v, cout_v, ovf_v;
    logic [15:0] sum_v [3];
    assign done_v = {if_c16.done, if_c1.done, if_c4.done};
    assign busy_v = {if_c16.busy, if_c1.busy, if_c4.busy};
    assign cout_v = {if_c16.Cout, if_c1.Cout, if_c4.Cout};
    assign ovf_v  = {if_c16.Ovf,  if_c1.Ovf,  if_c4.Ovf};
    assign sum_v[0] = if_c4.Sum;
    assign sum_v[1] = if_c1.Sum;
    assign sum_v[2] = if_c16.Sum;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input int d, input logic [1:0] m, input logic [15:0] a,
                          input logic [15:0] b, input logic c, output int lat);
        mode_r = m; a_r = a; b_r = b; cin_r = c;
        start_r[d] = 1'b1;
        @(posedge clk); #1;
        start_r[d] = 1'b0;
        lat = 1;
        while (done_v[d] !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op_check(input string tag, input int d, input logic [1:0] m,
                            input logic [15:0] a, input logic [15:0] b, input logic c,
                            input logic [15:0] e_sum, input logic e_cout, input logic e_ovf,
                            input int e_lat);
        int lat;
        run_op(d, m, a, b, c, lat);
        check({tag, "_lat"},  lat, e_lat);
        check({tag, "_sum"},  sum_v[d], e_sum);
        check({tag, "_cout"}, cout_v[d], e_cout);
        check({tag, "_ovf"},  ovf_v[d], e_ovf);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] acc_exp [3];
        logic [15:0] old_sum;
        logic [15:0] m11_sum;
        logic        m11_cout;
        rs_n = 1'b0; en_r = 1'b1; mode_r = 2'b00; a_r = '0; b_r = '0; cin_r = 1'b0; start_r = '0;

        #12;
        for (int d = 0; d < 3; d++) begin
            check("rst_sum",  sum_v[d], 16'h0);
            check("rst_busy", busy_v[d], 1'b0);
            check("rst_done", done_v[d], 1'b0);
            check("rst_cout", cout_v[d], 1'b0);
            check("rst_ovf",  ovf_v[d], 1'b0);
        end
        @(posedge clk); #1;
        rs_n = 1'b1;

        op_check("add_basic", 0, 2'b00, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 5);
        check("busy_after_done", busy_v[0], 1'b0);
        @(posedge clk); #1;
        check("done_fall", done_v[0], 1'b0);

        op_check("add_ovf",  0, 2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 5);
        op_check("sub_neg",  0, 2'b01, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 5);
        op_check("sub_pos",  0, 2'b01, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 5);
        op_check("sub_ovf",  0, 2'b01, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 5);

`ifdef RCA_ACCUM_EN
        m11_sum = 16'h0005; m11_cout = 1'b0;
        acc_exp[0] = 16'h0015; acc_exp[1] = 16'h001A; acc_exp[2] = 16'h001F;
`else
        m11_sum = 16'h0002; m11_cout = 1'b1;
        acc_exp[0] = 16'h0105; acc_exp[1] = 16'h0105; acc_exp[2] = 16'h0105;
`endif
        op_check("mode11", 0, 2'b11, 16'h0003, 16'h0001, 1'b1, m11_sum, m11_cout, 1'b0, 5);

        op_check("acc_seed", 0, 2'b00, 16'h0008, 16'h0008, 1'b0, 16'h0010, 1'b0, 1'b0, 5);
        for (int k = 0; k < 3; k++)
            op_check("acc", 0, 2'b10, 16'h0100, 16'h0005, 1'b0, acc_exp[k], 1'b0, 1'b0, 5);

        old_sum = sum_v[0];
        mode_r = 2'b00; a_r = 16'hF0F0; b_r = 16'h1111; cin_r = 1'b1;
        en_r = 1'b1; start_r[0] = 1'b1;
        @(posedge clk); #1;
        start_r[0] = 1'b0;
        check("en_busy_rise", busy_v[0], 1'b1);
        for (int i = 1; i <= 12; i++) begin
            en_r = (i % 3 == 0);
            start_r[0] = (i == 2 || i == 7);
            if (start_r[0]) a_r = 16'hFFFF;
            @(posedge clk); #1;
            if (i < 12) begin
                check("en_done_early", done_v[0], 1'b0);
                check("en_sum_held", sum_v[0], old_sum);
            end else begin
                check("en_done", done_v[0], 1'b1);
                check("en_sum", sum_v[0], 16'h0202);
                check("en_cout", cout_v[0], 1'b1);
                check("en_ovf", ovf_v[0], 1'b0);
            end
        end
        start_r[0] = 1'b0; en_r = 1'b1;
        @(posedge clk); #1;
        check("en_no_queue_busy", busy_v[0], 1'b0);
        check("en_done_fall", done_v[0], 1'b0);

        mode_r = 2'b00; a_r = 16'h1111; b_r = 16'h2222; cin_r = 1'b0;
        start_r[0] = 1'b1;
        @(posedge clk); #1;
        start_r[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rs_n = 1'b0;
        #1;
        check("abort_busy", busy_v[0], 1'b0);
        check("abort_done", done_v[0], 1'b0);
        check("abort_sum",  sum_v[0], 16'h0);
        check("abort_cout", cout_v[0], 1'b0);
        check("abort_ovf",  ovf_v[0], 1'b0);
        @(posedge clk); #1;
        check("abort_no_done", done_v[0], 1'b0);
        rs_n = 1'b1;
        op_check("post_rst", 0, 2'b00, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 5);

        op_check("sweep_c4",  0, 2'b00, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0, 5);
        op_check("sweep_c1",  1, 2'b00, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0, 17);
        op_check("sweep_c16", 2, 2'b00, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0, 2);
        op_check("c1_add",  1, 2'b00, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 17);
        op_check("c16_sub", 2, 2'b01, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
